// File: rtl/ysyx_22050710_dsram_arbiter_pkg.sv
// Shared core package for the data-side SRAM arbiter: SRAM width defaults and FSM encoding.
package ysyx_22050710_dsram_arbiter_pkg;

  localparam int SRAM_ADDR_WD_DEF  = 32;
  localparam int SRAM_DATA_WD_DEF  = 64;
  localparam int SRAM_WMASK_WD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } dsram_state_e;

endpackage

// File: rtl/ysyx_22050710_dsram_starve_cnt.sv
// Counts LS grants taken while fetch waits; forces fetch once STARVE_MAX is reached.
module ysyx_22050710_dsram_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  input  logic i_ls_gnt,
  output logic o_force_if
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Any fetch grant or fetch withdrawal restarts the fairness window.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_if_req || i_if_gnt) begin
      w_cnt_nxt = '0;
    end else if (i_ls_gnt && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  ysyx_22050710_reg #(
    .WIDTH     (CW),
    .RESET_VAL ('0)
  ) u_cnt_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_wen  (1'b1),
    .i_din  (w_cnt_nxt),
    .o_dout (r_cnt)
  );

  assign o_force_if = i_if_req && (r_cnt == CNT_MAX);

endmodule

// File: rtl/ysyx_22050710_reg.sv
// Codebase register primitive: async active-low reset, write enable, parameterised reset value.
module ysyx_22050710_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

// File: rtl/ysyx_22050710_dsram_arbiter.sv
// Arbitrates fetch and load/store onto one SRAM port with a single outstanding read.
// Starvation guard enabled by defining YSYX_22050710_DSRAM_STARVE_GUARD_EN.
module ysyx_22050710_dsram_arbiter
  import ysyx_22050710_dsram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WD  = SRAM_ADDR_WD_DEF,
  parameter int SRAM_DATA_WD  = SRAM_DATA_WD_DEF,
  parameter int SRAM_WMASK_WD = SRAM_WMASK_WD_DEF,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_if_req,
  input  logic [SRAM_ADDR_WD-1:0]  i_if_addr,
  output logic                     o_if_gnt,
  output logic                     o_if_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_if_rdata,
  input  logic                     i_ls_req,
  input  logic                     i_ls_wen,
  input  logic [SRAM_ADDR_WD-1:0]  i_ls_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_ls_wmask,
  input  logic [SRAM_DATA_WD-1:0]  i_ls_wdata,
  output logic                     o_ls_gnt,
  output logic                     o_ls_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_ls_rdata,
  output logic                     o_sram_en,
  output logic                     o_sram_wen,
  output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
  output logic [SRAM_WMASK_WD-1:0] o_sram_wmask,
  output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
  input  logic                     i_sram_ready,
  input  logic                     i_sram_rvalid,
  input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata
);

  logic [1:0]   r_state_q;
  logic [1:0]   w_state_nxt;
  dsram_state_e w_state;
  logic         w_idle;
  logic         w_force_if;
  logic         w_sel_ls;
  logic         w_sel_if;

  assign w_state = dsram_state_e'(r_state_q);

`ifdef YSYX_22050710_DSRAM_STARVE_GUARD_EN
  ysyx_22050710_dsram_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_if_req   (i_if_req),
    .i_if_gnt   (o_if_gnt),
    .i_ls_gnt   (o_ls_gnt),
    .o_force_if (w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif

  // Reset gates every output so they drop without waiting for a clock.
  assign w_idle   = i_rst && (w_state == IDLE);
  assign w_sel_ls = i_ls_req && !w_force_if;
  assign w_sel_if = i_if_req && !w_sel_ls;

  assign o_sram_en = w_idle && (i_if_req || i_ls_req);
  assign o_ls_gnt  = w_idle && w_sel_ls && i_sram_ready;
  assign o_if_gnt  = w_idle && w_sel_if && i_sram_ready;

  always_comb begin
    o_sram_wen   = 1'b0;
    o_sram_addr  = '0;
    o_sram_wmask = '0;
    o_sram_wdata = '0;
    if (w_idle && w_sel_ls) begin
      o_sram_wen   = i_ls_wen;
      o_sram_addr  = i_ls_addr;
      o_sram_wmask = i_ls_wmask;
      o_sram_wdata = i_ls_wdata;
    end else if (w_idle && w_sel_if) begin
      o_sram_addr  = i_if_addr;
    end
  end

  assign o_if_rvalid = i_rst && (w_state == RD_IF) && i_sram_rvalid;
  assign o_ls_rvalid = i_rst && (w_state == RD_LS) && i_sram_rvalid;
  assign o_if_rdata  = o_if_rvalid ? i_sram_rdata : '0;
  assign o_ls_rdata  = o_ls_rvalid ? i_sram_rdata : '0;

  // Stores complete on accept, so only reads leave IDLE.
  always_comb begin
    w_state_nxt = r_state_q;
    unique case (w_state)
      IDLE: begin
        if (o_if_gnt) begin
          w_state_nxt = RD_IF;
        end else if (o_ls_gnt && !i_ls_wen) begin
          w_state_nxt = RD_LS;
        end
      end
      RD_IF, RD_LS: begin
        if (i_sram_rvalid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ysyx_22050710_reg #(
    .WIDTH     (2),
    .RESET_VAL (IDLE)
  ) u_state_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_wen  (1'b1),
    .i_din  (w_state_nxt),
    .o_dout (r_state_q)
  );

endmodule

// File: tb/tb_ysyx_22050710_dsram_arbiter.sv
// Directed bench for ysyx_22050710_dsram_arbiter; expected values are hand-computed constants.
module tb_ysyx_22050710_dsram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [7:0]  ls_wmask;
  logic [63:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        sram_en;
  logic        sram_wen;
  logic [31:0] sram_addr;
  logic [7:0]  sram_wmask;
  logic [63:0] sram_wdata;
  logic        sram_ready;
  logic        sram_rvalid;
  logic [63:0] sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ls;
  logic got_if;

  // clock / reset
  always #5 clk = ~clk;

  ysyx_22050710_dsram_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_if_req      (if_req),
    .i_if_addr     (if_addr),
    .o_if_gnt      (if_gnt),
    .o_if_rvalid   (if_rvalid),
    .o_if_rdata    (if_rdata),
    .i_ls_req      (ls_req),
    .i_ls_wen      (ls_wen),
    .i_ls_addr     (ls_addr),
    .i_ls_wmask    (ls_wmask),
    .i_ls_wdata    (ls_wdata),
    .o_ls_gnt      (ls_gnt),
    .o_ls_rvalid   (ls_rvalid),
    .o_ls_rdata    (ls_rdata),
    .o_sram_en     (sram_en),
    .o_sram_wen    (sram_wen),
    .o_sram_addr   (sram_addr),
    .o_sram_wmask  (sram_wmask),
    .o_sram_wdata  (sram_wdata),
    .i_sram_ready  (sram_ready),
    .i_sram_rvalid (sram_rvalid),
    .i_sram_rdata  (sram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wmask = '0; ls_wdata = '0;
    sram_rvalid = 1'b0; sram_rdata = '0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    sram_ready  = 1'b1;
    if_req      = 1'b1;
    ls_req      = 1'b1;
    sram_rvalid = 1'b1;
    sram_rdata  = 64'hFFFF_0000_FFFF_0000;
    #3;
    check("rst_en",       sram_en,   0);
    check("rst_if_gnt",   if_gnt,    0);
    check("rst_ls_gnt",   ls_gnt,    0);
    check("rst_if_rv",    if_rvalid, 0);
    check("rst_ls_rv",    ls_rvalid, 0);
    check("rst_ls_rdata", ls_rdata,  0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // fetch-only read
    if_req = 1'b1; if_addr = 32'h8000_0000; #1;
    check("if_en",    sram_en,   1);
    check("if_addr",  sram_addr, 64'h8000_0000);
    check("if_gnt",   if_gnt,    1);
    check("if_nols",  ls_gnt,    0);
    check("if_wen",   sram_wen,  0);
    cyc();
    if_req = 1'b0; #1;
    check("rdif_en",   sram_en,   0);
    check("rdif_addr", sram_addr, 0);
    check("rdif_rv0",  if_rvalid, 0);
    cyc();
    sram_rvalid = 1'b1; sram_rdata = 64'h1122_3344_5566_7788; #1;
    check("if_rv",     if_rvalid, 1);
    check("if_rdata",  if_rdata,  64'h1122_3344_5566_7788);
    check("if_ls_rv0", ls_rvalid, 0);
    check("if_ret_gnt", if_gnt,   0);
    cyc();
    sram_rdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    check("idle_rv_ign", if_rvalid, 0);
    check("idle_rdata0", if_rdata,  0);
    sram_rvalid = 1'b0;

    // simultaneous fetch and load: LS wins, IF follows
    if_req = 1'b1; if_addr = 32'h8000_0004;
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h0000_1000; #1;
    check("both_ls_gnt", ls_gnt,    1);
    check("both_if_gnt", if_gnt,    0);
    check("both_addr",   sram_addr, 64'h1000);
    cyc();
    ls_req = 1'b0; #1;
    check("rdls_if_gnt", if_gnt,  0);
    check("rdls_en",     sram_en, 0);
    cyc();
    sram_rvalid = 1'b1; sram_rdata = 64'hA5A5_5A5A_0102_0304; #1;
    check("ls_rv",       ls_rvalid, 1);
    check("ls_rdata",    ls_rdata,  64'hA5A5_5A5A_0102_0304);
    check("ls_ret_gnt",  if_gnt,    0);
    check("ls_if_rv0",   if_rvalid, 0);
    cyc();
    sram_rvalid = 1'b0; #1;
    check("after_ls_if_gnt", if_gnt,    1);
    check("after_ls_addr",   sram_addr, 64'h8000_0004);
    cyc();
    if_req = 1'b0; sram_rvalid = 1'b1; sram_rdata = 64'h0F0F; #1;
    check("if2_rv", if_rvalid, 1);
    cyc();
    sram_rvalid = 1'b0;

    // store: no read phase, next grant the following cycle
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h0000_2000;
    ls_wmask = 8'h0F; ls_wdata = 64'hDEAD_BEEF; #1;
    check("st_gnt",   ls_gnt,     1);
    check("st_wen",   sram_wen,   1);
    check("st_wmask", sram_wmask, 8'h0F);
    check("st_wdata", sram_wdata, 64'hDEAD_BEEF);
    check("st_addr",  sram_addr,  64'h2000);
    cyc();
    clear_inputs();
    if_req = 1'b1; if_addr = 32'h8000_0008; #1;
    check("st_next_gnt", if_gnt,    1);
    check("st_no_rv",    ls_rvalid, 0);
    cyc();
    if_req = 1'b0; sram_rvalid = 1'b1; #1;
    check("if3_rv", if_rvalid, 1);
    cyc();
    sram_rvalid = 1'b0;

    // backpressure holds selection and fields
    sram_ready = 1'b0;
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h0000_3000;
    if_req = 1'b1; if_addr = 32'h8000_000C;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_en",     sram_en,   1);
      check("bp_addr",   sram_addr, 64'h3000);
      check("bp_ls_gnt", ls_gnt,    0);
      check("bp_if_gnt", if_gnt,    0);
      cyc();
    end
    if_req = 1'b0; ls_req = 1'b0; #1;
    check("drop_en", sram_en, 0);
    cyc();

    // reset in RD_LS abandons the read
    sram_ready = 1'b1; ls_req = 1'b1; #1;
    check("rl_gnt", ls_gnt, 1);
    cyc();
    ls_req = 1'b0;
    rst = 1'b0; sram_rvalid = 1'b1; sram_rdata = 64'h1234; #1;
    check("rl_rst_rv",    ls_rvalid, 0);
    check("rl_rst_rdata", ls_rdata,  0);
    cyc();
    rst = 1'b1; #1;
    check("rl_post_rv", ls_rvalid, 0);
    check("rl_post_en", sram_en,   0);
    cyc();
    #1;
    check("rl_post_rv2", ls_rvalid, 0);
    sram_rvalid = 1'b0;

    // continuous stores vs. waiting fetch
    if_req = 1'b1; if_addr = 32'h8000_0010;
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h0000_4000; ls_wmask = 8'hFF; ls_wdata = 64'h55;
    n_ls = 0; got_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!got_if) begin
        #1;
        if (if_gnt) got_if = 1'b1;
        else if (ls_gnt) n_ls++;
        cyc();
      end
    end
`ifdef YSYX_22050710_DSRAM_STARVE_GUARD_EN
    check("starve_ls_cnt", n_ls,   4);
    check("starve_if",     got_if, 1);
    sram_rvalid = 1'b1; #1;
    check("starve_if_rv", if_rvalid, 1);
    cyc();
    sram_rvalid = 1'b0; #1;
    check("starve_clr_ls", ls_gnt, 1);
    check("starve_clr_if", if_gnt, 0);
`else
    check("strict_ls_cnt", n_ls,   10);
    check("strict_no_if",  got_if, 0);
`endif
    clear_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1);
  end

endmodule
